// File: rtl/contador_pkg.sv
// contador_pkg: shared default sizing for the contador counter.
package contador_pkg;
  localparam int DEFAULT_WIDTH       = 3;
  localparam int DEFAULT_SYNC_STAGES = 2;
endpackage

// File: rtl/edge_sync.sv
// edge_sync: synchronizes an async level and emits a one-cycle pulse on its rising edge.
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_pulse
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end
  assign o_pulse = r_sync[STAGES-1] & ~r_prev;
endmodule

// File: rtl/contador.sv
// contador: up/down counter driven by edges of two asynchronous command levels.
module contador
  import contador_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sum,
  input  logic             res,
  output logic [WIDTH-1:0] count
);
  logic             w_inc;
  logic             w_dec;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] r_count;
  edge_sync #(.STAGES(SYNC_STAGES)) u_sum (.clk(clk), .rst(reset), .i_d(sum), .o_pulse(w_inc));
  edge_sync #(.STAGES(SYNC_STAGES)) u_res (.clk(clk), .rst(reset), .i_d(res), .o_pulse(w_dec));
  // simultaneous inc and dec cancel out and hold
  always_comb w_next = (w_inc ^ w_dec) ? (w_inc ? r_count + 1'b1 : r_count - 1'b1) : r_count;
  always_ff @(posedge clk) r_count <= reset ? '0 : w_next;
  assign count = r_count;
endmodule

// File: tb/tb_contador.sv
// tb_contador: directed checks of contador plus a per-cycle reference monitor.
module tb_contador;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sum = 1'b0;
  logic       res = 1'b0;
  logic [2:0] count;
  int         n_run = 0;
  int         n_fail = 0;
  logic       armed = 1'b0;
  logic [2:0] h_sum = '0;
  logic [2:0] h_res = '0;
  logic [2:0] m_count = '0;
  contador dut (.clk(clk), .reset(reset), .sum(sum), .res(res), .count(count));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  task automatic pulse_sum(input int hi, input int lo);
    sum = 1'b1;
    tick(hi);
    sum = 1'b0;
    tick(lo);
  endtask
  // reference: two sampling stages plus a previous flop per input
  always @(posedge clk) begin
    if (reset) begin
      armed   <= 1'b1;
      h_sum   <= '0;
      h_res   <= '0;
      m_count <= '0;
    end else begin
      h_sum <= {h_sum[1:0], sum};
      h_res <= {h_res[1:0], res};
      if ((h_sum[1] & ~h_sum[2]) && !(h_res[1] & ~h_res[2])) m_count <= m_count + 3'd1;
      else if ((h_res[1] & ~h_res[2]) && !(h_sum[1] & ~h_sum[2])) m_count <= m_count - 3'd1;
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      check("no_x", {31'd0, $isunknown(count)}, 32'd0);
      check("cycle_model", {29'd0, count}, {29'd0, m_count});
    end
  end
  initial begin
    do_reset();
    check("reset", {29'd0, count}, 32'd0);
    sum = 1'b1;
    tick();
    check("lat_e1", {29'd0, count}, 32'd0);
    tick();
    check("lat_e2", {29'd0, count}, 32'd0);
    tick();
    check("lat_e3", {29'd0, count}, 32'd1);
    tick(6);
    check("hold_level", {29'd0, count}, 32'd1);
    sum = 1'b0;
    tick(3);
    do_reset();
    pulse_sum(2, 3);
    check("pulse1", {29'd0, count}, 32'd1);
    pulse_sum(2, 3);
    check("pulse2", {29'd0, count}, 32'd2);
    pulse_sum(2, 3);
    check("pulse3", {29'd0, count}, 32'd3);
    res = 1'b1;
    tick(5);
    check("res_level", {29'd0, count}, 32'd2);
    res = 1'b0;
    tick(3);
    check("res_after", {29'd0, count}, 32'd2);
    do_reset();
    repeat (7) pulse_sum(2, 3);
    check("up_to_7", {29'd0, count}, 32'd7);
    pulse_sum(2, 3);
    check("wrap_up", {29'd0, count}, 32'd0);
    res = 1'b1;
    tick(2);
    res = 1'b0;
    tick(3);
    check("wrap_down", {29'd0, count}, 32'd7);
    do_reset();
    repeat (4) pulse_sum(2, 3);
    check("at_4", {29'd0, count}, 32'd4);
    sum = 1'b1;
    res = 1'b1;
    tick(2);
    sum = 1'b0;
    res = 1'b0;
    tick(3);
    check("simul_hold", {29'd0, count}, 32'd4);
    sum = 1'b1;
    tick();
    res = 1'b1;
    tick(2);
    check("stagger_inc", {29'd0, count}, 32'd5);
    tick();
    check("stagger_dec", {29'd0, count}, 32'd4);
    sum = 1'b0;
    res = 1'b0;
    tick(3);
    do_reset();
    repeat (5) pulse_sum(2, 3);
    check("at_5", {29'd0, count}, 32'd5);
    sum = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check("mid_reset", {29'd0, count}, 32'd0);
    reset = 1'b0;
    tick(2);
    check("post_rst_e2", {29'd0, count}, 32'd0);
    tick();
    check("post_rst_e3", {29'd0, count}, 32'd1);
    tick(5);
    check("post_rst_hold", {29'd0, count}, 32'd1);
    sum = 1'b0;
    tick(3);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/contador.md
CONTADOR -- requirements
Module: contador

Interface
REQ-001 Parameter WIDTH, default 3: counter width in bits.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2: number of synchronizer flops per command input.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port sum, input, 1 bit: asynchronous increment request, level signal; one increment per rising edge.
REQ-006 Port res, input, 1 bit: asynchronous decrement request, level signal; one decrement per rising edge.
REQ-007 Port count, output, WIDTH bits: current counter value, driven directly from a register.

Function
REQ-008 The block SHALL pass sum and res each through a chain of SYNC_STAGES flops before any use.
REQ-009 The block SHALL hold one extra "previous" flop per input and derive inc_evt = sync_sum & ~prev_sum and dec_evt = sync_res & ~prev_res.
REQ-010 A level held high for any number of cycles SHALL produce exactly one event.
REQ-011 With SYNC_STAGES=2, count SHALL change on the 3rd rising clk edge counting the first edge that samples the input high.
REQ-012 When inc_evt=1 and dec_evt=0, count SHALL become count+1 modulo 2^WIDTH (7 -> 0 at WIDTH=3).
REQ-013 When dec_evt=1 and inc_evt=0, count SHALL become count-1 modulo 2^WIDTH (0 -> 7 at WIDTH=3).
REQ-014 When inc_evt and dec_evt are both 1 in the same cycle, count SHALL hold.
REQ-015 When neither event is active, count SHALL hold.
REQ-016 An input pulse shorter than one clk period MAY be missed; no event is guaranteed for it.
REQ-017 Input levels SHALL be at least 1 clk cycle high and 1 cycle low to guarantee each event.
REQ-018 No combinational path SHALL exist from sum or res to count.

Reset
REQ-019 While reset=1 at a rising clk edge, count SHALL become 0, and all synchronizer and previous flops SHALL become 0.
REQ-020 Reset SHALL take priority over any pending event.
REQ-021 Reset asserted mid-count SHALL clear count on that edge; a command level that is still high when reset is released SHALL produce exactly one event after release.
REQ-022 The block SHALL use no asynchronous reset and no other clock.

Structure
REQ-023 A shared package contador_pkg SHALL hold the default WIDTH and SYNC_STAGES constants.
REQ-024 One sub-module, edge_sync, SHALL implement the synchronizer chain, the previous flop and the rising-edge pulse.
REQ-025 contador SHALL instantiate edge_sync twice, once for sum and once for res.
REQ-026 contador SHALL contain the up/down register and the priority logic: reset, then simultaneous-hold, then inc/dec.

Verification
REQ-027 Reset 1 cycle, then sum held high 9 cycles with res=0 -> count goes 0 -> 1 exactly once, 3 edges after sum rises, and stays 1.
REQ-028 From count=0, three sum pulses (each 2 cycles high, 3 low) -> count 1, 2, 3; then res held high 5 cycles -> count 2, held.
REQ-029 Eight sum pulses from 0 -> count reaches 7 then wraps to 0; one res pulse at 0 -> count 7.
REQ-030 sum and res rising on the same edge with count=4 -> count remains 4; staggered by 1 cycle -> 5 then 4.
REQ-031 Count at 5, reset asserted 1 cycle while sum is high -> count 0 on that edge; after release with sum still high -> count 1 once.
REQ-032 Check on every cycle: no count change without a preceding synchronized edge, and count never takes X after the first reset.
